// File: rtl/stall_inj_pkg.sv
// stall_inj_pkg: shared types and helpers for the stall injector.
//   state_e   - injector FSM states
//   LFSR_TAPS - Galois feedback mask for the 16-bit PRNG
//   sat_inc   - saturating increment used by both statistics counters
package stall_inj_pkg;

  localparam int unsigned STAT_W = 32;
  localparam int unsigned THR_W  = 8;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    STALL = 2'd2
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/stall_inj_lfsr.sv
// stall_inj_lfsr: right-shifting Galois LFSR.
//   clk, rst_n - clock, synchronous active-low reset (state resets to 1)
//   load, seed - load seed (a zero seed is replaced by 1); load wins over adv
//   adv        - advance one step
//   value      - current register contents
module stall_inj_lfsr #(
  parameter int unsigned      W    = 16,
  parameter logic [W-1:0]     TAPS = W'(16'hB400)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         adv,
  output logic [W-1:0] value
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  // Next value: load (zero seed would lock the LFSR, so map it to 1), step, or hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? W'(1) : seed;
    end else if (adv) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= W'(1);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/stall_injector.sv
// stall_injector: inline valid/ready bubble injector with reproducible stall windows.
//   clk, rst_n              - clock, synchronous active-low reset
//   cfg_we                  - latch cfg_*, reseed PRNG, clear statistics
//   cfg_en/thr/min_len/max_len/seed - injection knobs
//   s_valid/s_ready/s_data  - upstream channel
//   m_valid/m_ready/m_data  - downstream channel (combinational, zero latency)
//   stat_stall_cyc          - saturating count of STALL cycles
//   stat_xfers              - saturating count of accepted downstream beats
module stall_injector
  import stall_inj_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LFSR_W = 16  // must be >= 8 + CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic              cfg_en,
  input  logic [THR_W-1:0]  cfg_thr,
  input  logic [CNT_W-1:0]  cfg_min_len,
  input  logic [CNT_W-1:0]  cfg_max_len,
  input  logic [LFSR_W-1:0] cfg_seed,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [STAT_W-1:0] stat_stall_cyc,
  output logic [STAT_W-1:0] stat_xfers
);

  state_e             state_q, state_d;
  logic               en_q, en_d;
  logic [THR_W-1:0]   thr_q, thr_d;
  logic [CNT_W-1:0]   min_len_q, min_len_d;
  logic [CNT_W-1:0]   max_len_q, max_len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [STAT_W-1:0]  stall_cyc_q, stall_cyc_d;
  logic [STAT_W-1:0]  xfers_q, xfers_d;

  logic [LFSR_W-1:0]  lfsr;
  logic               gate;
  logic               hold;
  logic               draw;
  logic [CNT_W-1:0]   len_r, len_lo, len_hi, stall_len;

  stall_inj_lfsr #(
    .W    (LFSR_W),
    .TAPS (LFSR_W'(LFSR_TAPS))
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cfg_we),
    .seed  (cfg_seed),
    .adv   (state_q != IDLE),
    .value (lfsr)
  );

  if (LFSR_W > 8 + CNT_W) begin : g_lfsr_hi
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:8+CNT_W];
  end

  // Datapath: gating only ever removes valid/ready, data passes untouched.
  always_comb begin
    gate    = (state_q == STALL);
    m_data  = s_data;
    m_valid = s_valid & ~gate;
    s_ready = m_ready & ~gate;
    hold    = m_valid & ~m_ready;
  end

  // Config registers; en_d is the enable that will be in force next cycle.
  always_comb begin
    en_d      = en_q;
    thr_d     = thr_q;
    min_len_d = min_len_q;
    max_len_d = max_len_q;
    if (cfg_we) begin
      en_d      = cfg_en;
      thr_d     = cfg_thr;
      min_len_d = cfg_min_len;
      max_len_d = cfg_max_len;
    end
  end

  // Stall length: clamp the PRNG field into [max(min,1), max(max, lo)].
  always_comb begin
    len_r     = lfsr[8 +: CNT_W];
    len_lo    = (min_len_q == '0) ? CNT_W'(1) : min_len_q;
    len_hi    = (max_len_q < len_lo) ? len_lo : max_len_q;
    stall_len = len_r;
    if (len_r < len_lo) begin
      stall_len = len_lo;
    end else if (len_r > len_hi) begin
      stall_len = len_hi;
    end
  end

  // A stall may only start when no beat is being offered-and-held, now or last cycle.
  always_comb begin
    draw = (lfsr[7:0] < thr_q) & ~pend_q & ~hold;
  end

  // Injector FSM next state and stall counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = PASS;
      end
      PASS: begin
        if (draw) begin
          state_d = STALL;
          cnt_d   = stall_len;
        end
      end
      STALL: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = PASS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Disabling drops any stall at once; removing valid is always legal.
    if (!en_d) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Pending guard and statistics; cfg_we clear beats a same-cycle increment.
  always_comb begin
    pend_d      = hold;
    stall_cyc_d = stall_cyc_q;
    xfers_d     = xfers_q;
    if (cfg_we) begin
      stall_cyc_d = '0;
      xfers_d     = '0;
    end else begin
      if (gate) begin
        stall_cyc_d = sat_inc(stall_cyc_q);
      end
      if (m_valid && m_ready) begin
        xfers_d = sat_inc(xfers_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      thr_q       <= '0;
      min_len_q   <= '0;
      max_len_q   <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      stall_cyc_q <= '0;
      xfers_q     <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      thr_q       <= thr_d;
      min_len_q   <= min_len_d;
      max_len_q   <= max_len_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      stall_cyc_q <= stall_cyc_d;
      xfers_q     <= xfers_d;
    end
  end

  assign stat_stall_cyc = stall_cyc_q;
  assign stat_xfers     = xfers_q;

endmodule

// File: tb/tb_stall_injector.sv
// tb_stall_injector: directed + randomized checks of stall_injector against a
// cycle-level reference model kept in the bench.
module tb_stall_injector;
  import stall_inj_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic        cfg_en;
  logic [7:0]  cfg_thr;
  logic [7:0]  cfg_min_len;
  logic [7:0]  cfg_max_len;
  logic [15:0] cfg_seed;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [31:0] stat_stall_cyc;
  logic [31:0] stat_xfers;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          md_en, md_run, md_pend;
  int unsigned md_thr, md_min, md_max, md_lfsr, md_left;
  int unsigned md_stall, md_xfers;

  bit          tr_a[64];
  bit          tr_b[64];

  stall_injector #(.DATA_W(32), .CNT_W(8), .LFSR_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_we         (cfg_we),
    .cfg_en         (cfg_en),
    .cfg_thr        (cfg_thr),
    .cfg_min_len    (cfg_min_len),
    .cfg_max_len    (cfg_max_len),
    .cfg_seed       (cfg_seed),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .stat_stall_cyc (stat_stall_cyc),
    .stat_xfers     (stat_xfers)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned x);
    return (x & 1) ? ((x >> 1) ^ 32'hB400) : (x >> 1);
  endfunction

  function automatic int unsigned model_len();
    int unsigned r, lo, hi;
    r  = (md_lfsr >> 8) & 255;
    lo = (md_min == 0) ? 1 : md_min;
    hi = (md_max < lo) ? lo : md_max;
    if (r < lo) return lo;
    if (r > hi) return hi;
    return r;
  endfunction

  task automatic model_reset();
    md_en = 0; md_run = 0; md_pend = 0;
    md_thr = 0; md_min = 0; md_max = 0;
    md_lfsr = 1; md_left = 0; md_stall = 0; md_xfers = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit gate, mv, hold, xfer, n_en, draw;
    if (!rst_n) begin
      model_reset();
      return;
    end
    gate = (md_left != 0);
    mv   = s_valid && !gate;
    hold = mv && !m_ready;
    xfer = mv && m_ready;
    n_en = cfg_we ? cfg_en : md_en;
    draw = md_run && !gate && ((md_lfsr & 255) < md_thr) && !md_pend && !hold;
    if (!n_en)      md_left = 0;
    else if (gate)  md_left = md_left - 1;
    else if (draw)  md_left = model_len();
    else            md_left = 0;
    if (cfg_we)      md_lfsr = (cfg_seed == 0) ? 1 : cfg_seed;
    else if (md_run) md_lfsr = lfsr_next(md_lfsr);
    if (cfg_we) begin
      md_stall = 0;
      md_xfers = 0;
    end else begin
      if (gate && md_stall != 32'hFFFF_FFFF) md_stall++;
      if (xfer && md_xfers != 32'hFFFF_FFFF) md_xfers++;
    end
    md_pend = hold;
    if (cfg_we) begin
      md_thr = cfg_thr; md_min = cfg_min_len; md_max = cfg_max_len;
    end
    md_en  = n_en;
    md_run = n_en;
  endtask

  // One clock: compare outputs mid-cycle, step the model, land just after the edge.
  task automatic tick();
    @(negedge clk);
    chk("m_valid", 32'(m_valid), 32'(s_valid && md_left == 0));
    chk("s_ready", 32'(s_ready), 32'(m_ready && md_left == 0));
    chk("m_data", m_data, s_data);
    chk("stat_stall_cyc", stat_stall_cyc, md_stall);
    chk("stat_xfers", stat_xfers, md_xfers);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input bit en, input int unsigned thr, input int unsigned mn,
                           input int unsigned mx, input int unsigned seed);
    cfg_we = 1'b1; cfg_en = en; cfg_thr = 8'(thr);
    cfg_min_len = 8'(mn); cfg_max_len = 8'(mx); cfg_seed = 16'(seed);
    tick();
    cfg_we = 1'b0;
  endtask

  // Random m_ready with s_valid high; every completed gate window must have length exp_len.
  task automatic track_windows(input int n, input int unsigned exp_len, input string tag,
                               output int unsigned gate_cyc, output int unsigned nwin);
    int unsigned run;
    run = 0; gate_cyc = 0; nwin = 0;
    s_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      if (!m_valid) begin
        run++;
        gate_cyc++;
      end else if (run != 0) begin
        chk(tag, run, exp_len);
        nwin++;
        run = 0;
      end
      tick();
    end
  endtask

  initial begin
    int unsigned gc, nw, diff;
    bit found;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_en = 1'b0; cfg_thr = '0;
    cfg_min_len = '0; cfg_max_len = '0; cfg_seed = '0;
    s_valid = 1'b1; m_ready = 1'b0; s_data = 32'h1234_5678;
    @(posedge clk); #1;
    model_reset();
    tick();
    rst_n = 1'b1;

    // Reset state.
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'd1);
    chk("rst_mvalid", 32'(m_valid), 32'd1);
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("rst_stats", stat_stall_cyc | stat_xfers, 32'd0);

    // Disabled: pure pass-through under random traffic.
    for (int i = 0; i < 40; i++) begin
      s_valid = 1'($urandom_range(0, 1)); m_ready = 1'($urandom_range(0, 1));
      s_data = $urandom;
      tick();
    end

    // thr=0: no stalls, 100 beats in 100 cycles.
    s_valid = 1'b1; m_ready = 1'b1;
    configure(1, 0, 2, 5, 16'h5555);
    for (int i = 0; i < 100; i++) begin
      s_data = $urandom;
      tick();
    end
    chk("thr0_xfers", stat_xfers, 32'd100);
    chk("thr0_stall", stat_stall_cyc, 32'd0);

    // thr=255, min=max=3: every window exactly 3; stall count matches bench count.
    configure(0, 0, 0, 0, 0);
    configure(1, 255, 3, 3, 16'h0F0F);
    track_windows(150, 3, "win_len3", gc, nw);
    chk("win3_seen", 32'(nw > 5), 32'd1);
    chk("win3_stall_cnt", stat_stall_cyc, gc);

    // Pending guard: no stall while a beat is held; stall follows the handshake.
    configure(0, 0, 0, 0, 0);
    s_valid = 1'b1; m_ready = 1'b0;
    configure(1, 255, 2, 2, 16'h1234);
    for (int i = 0; i < 20; i++) begin
      chk("hold_mvalid", 32'(m_valid), 32'd1);
      tick();
    end
    m_ready = 1'b1;
    chk("hs_mvalid", 32'(m_valid), 32'd1);
    tick();
    chk("post_hs_guard", 32'(m_valid), 32'd1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (!m_valid) found = 1;
    end
    chk("stall_after_hs", 32'(found), 32'd1);

    // Seed 0 and seed 1 give identical gate traces.
    configure(0, 0, 0, 0, 0);
    configure(1, 128, 1, 4, 0);
    chk("seed0_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'd1);
    for (int i = 0; i < 64; i++) begin tr_a[i] = !m_valid; tick(); end
    configure(0, 0, 0, 0, 0);
    configure(1, 128, 1, 4, 1);
    for (int i = 0; i < 64; i++) begin tr_b[i] = !m_valid; tick(); end
    diff = 0; gc = 0;
    for (int i = 0; i < 64; i++) begin
      if (tr_a[i] != tr_b[i]) diff++;
      if (tr_a[i]) gc++;
    end
    chk("seed0_vs_seed1", diff, 32'd0);
    chk("seed_trace_active", 32'(gc > 0), 32'd1);

    // Two runs with seed 0xACE1 match bit for bit.
    configure(0, 0, 0, 0, 0);
    configure(1, 90, 1, 6, 16'hACE1);
    for (int i = 0; i < 64; i++) begin tr_a[i] = !m_valid; tick(); end
    configure(0, 0, 0, 0, 0);
    configure(1, 90, 1, 6, 16'hACE1);
    for (int i = 0; i < 64; i++) begin tr_b[i] = !m_valid; tick(); end
    diff = 0;
    for (int i = 0; i < 64; i++) if (tr_a[i] != tr_b[i]) diff++;
    chk("ace1_repeat", diff, 32'd0);

    // Drop cfg_en in cycle 2 of a 5-cycle stall.
    configure(0, 0, 0, 0, 0);
    configure(1, 255, 5, 5, 16'h2468);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (!m_valid) found = 1; else tick();
    end
    chk("en_drop_found_stall", 32'(found), 32'd1);
    tick();
    chk("en_drop_cycle2_gate", 32'(m_valid), 32'd0);
    cfg_we = 1'b1; cfg_en = 1'b0;
    tick();
    cfg_we = 1'b0;
    chk("en_drop_gate_low", 32'(m_valid), 32'd1);
    chk("en_drop_idle", 32'(dut.state_q), 32'(IDLE));

    // min=9 > max=4 gives L=9, then reset mid-stall.
    configure(1, 255, 9, 4, 16'h7777);
    track_windows(200, 9, "win_len9", gc, nw);
    chk("win9_seen", 32'(nw > 3), 32'd1);
    s_valid = 1'b1; m_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (!m_valid) found = 1; else tick();
    end
    chk("rst_mid_found_stall", 32'(found), 32'd1);
    chk("rst_mid_stats_nz", 32'(stat_stall_cyc != 0), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_gate", 32'(m_valid), 32'd1);
    chk("rst_mid_stall_stat", stat_stall_cyc, 32'd0);
    chk("rst_mid_xfer_stat", stat_xfers, 32'd0);
    chk("rst_mid_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'd1);
    chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));

    // Random traffic with random knobs against the model.
    configure(1, 100, 2, 6, 16'hBEEF);
    for (int i = 0; i < 300; i++) begin
      s_valid = 1'($urandom_range(0, 1)); m_ready = 1'($urandom_range(0, 1));
      s_data = $urandom;
      if (i == 150) begin
        cfg_we = 1'b1; cfg_en = 1'b1; cfg_thr = 8'($urandom_range(0, 255));
        cfg_min_len = 8'($urandom_range(0, 4)); cfg_max_len = 8'($urandom_range(0, 8));
        cfg_seed = 16'($urandom);
      end else begin
        cfg_we = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
